// File: rtl/fifo_bank4_if.sv
// Handshake and status bundle between the class arbiter / next stage and
// the four-class FIFO bank.
interface fifo_bank4_if #(
   parameter int DATA_WIDTH = 12
);
   logic [DATA_WIDTH-1:0]   data_in;
   logic [3:0]              push;
   logic [3:0]              pop;
   logic [4*DATA_WIDTH-1:0] data_out;
   logic [3:0]              valid_out;
   logic [3:0]              empty;
   logic [3:0]              full;
   logic [3:0]              almost_full;
   logic [3:0]              almost_empty;
   logic [3:0]              err_overflow;
   logic [3:0]              err_underflow;

   modport master (
      output data_in, push, pop,
      input  data_out, valid_out, empty, full, almost_full, almost_empty,
             err_overflow, err_underflow
   );

   modport slave (
      input  data_in, push, pop,
      output data_out, valid_out, empty, full, almost_full, almost_empty,
             err_overflow, err_underflow
   );
endinterface

// File: rtl/fifo_bank4.sv
// Bank of four independent synchronous FIFOs, one per traffic class.
// Shared write word, per-class push/pop, registered read data with 1-cycle
// latency, count-decoded status flags and sticky overflow/underflow errors.
module fifo_bank4 #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 2
) (
   input logic          clk,
   input logic          reset,
   fifo_bank4_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem_q      [4][DEPTH];
   logic [DATA_WIDTH-1:0] mem_d      [4][DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q   [4];
   logic [ADDR_WIDTH-1:0] wr_ptr_d   [4];
   logic [ADDR_WIDTH-1:0] rd_ptr_q   [4];
   logic [ADDR_WIDTH-1:0] rd_ptr_d   [4];
   logic [CW-1:0]         count_q    [4];
   logic [CW-1:0]         count_d    [4];
   logic [DATA_WIDTH-1:0] data_out_q [4];
   logic [DATA_WIDTH-1:0] data_out_d [4];
   logic [3:0]            valid_q, valid_d;
   logic [3:0]            err_ov_q, err_ov_d;
   logic [3:0]            err_un_q, err_un_d;

   logic [3:0] empty_s, full_s, af_s, ae_s;
   logic [3:0] wr_en, rd_en;

   // Status flags decoded from the registered counts.
   always_comb begin
      empty_s = '0;
      full_s  = '0;
      af_s    = '0;
      ae_s    = '0;
      for (int i = 0; i < 4; i++) begin
         empty_s[i] = (count_q[i] == '0);
         full_s[i]  = (count_q[i] == DEPTH_C);
         af_s[i]    = (count_q[i] >= AF_C);
         ae_s[i]    = (count_q[i] <= AE_C);
      end
   end

   // Read/write qualification; a full FIFO still accepts a push when it is
   // popped in the same cycle, since the read frees the slot being written.
   always_comb begin
      rd_en = bus.pop & ~empty_s;
      wr_en = bus.push & (~full_s | rd_en);
   end

   // Next-state for memory, pointers, counts, read data and error bits.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      data_out_d = data_out_q;
      valid_d    = '0;
      err_ov_d   = err_ov_q | (bus.push & full_s & ~bus.pop);
      err_un_d   = err_un_q | (bus.pop & empty_s);
      for (int i = 0; i < 4; i++) begin
         if (wr_en[i]) begin
            mem_d[i][wr_ptr_q[i]] = bus.data_in;
            wr_ptr_d[i]           = wr_ptr_q[i] + ADDR_WIDTH'(1);
         end
         if (rd_en[i]) begin
            data_out_d[i] = mem_q[i][rd_ptr_q[i]];
            rd_ptr_d[i]   = rd_ptr_q[i] + ADDR_WIDTH'(1);
            valid_d[i]    = 1'b1;
         end
         case ({wr_en[i], rd_en[i]})
            2'b10:   count_d[i] = count_q[i] + CW'(1);
            2'b01:   count_d[i] = count_q[i] - CW'(1);
            default: count_d[i] = count_q[i];
         endcase
      end
   end

   // State registers; memory contents are left untouched by reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            wr_ptr_q[i]   <= '0;
            rd_ptr_q[i]   <= '0;
            count_q[i]    <= '0;
            data_out_q[i] <= '0;
         end
         valid_q  <= '0;
         err_ov_q <= '0;
         err_un_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         err_ov_q   <= err_ov_d;
         err_un_q   <= err_un_d;
      end
   end

   // Pack per-class read data onto the flat output bus.
   always_comb begin
      bus.data_out = '0;
      for (int i = 0; i < 4; i++)
         bus.data_out[i*DATA_WIDTH +: DATA_WIDTH] = data_out_q[i];
   end

   assign bus.valid_out     = valid_q;
   assign bus.empty         = empty_s;
   assign bus.full          = full_s;
   assign bus.almost_full   = af_s;
   assign bus.almost_empty  = ae_s;
   assign bus.err_overflow  = err_ov_q;
   assign bus.err_underflow = err_un_q;
endmodule

// File: tb/tb_fifo_bank4.sv
// Bench for fifo_bank4: directed boundary steps plus random traffic, all
// checked against a queue-based reference model of the four FIFOs.
module tb_fifo_bank4;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   fifo_bank4_if #(.DATA_WIDTH(12)) bus ();

   fifo_bank4 #(
      .DATA_WIDTH(12), .ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // reference model
   logic [11:0] mq [4][$];
   logic [11:0] exp_dout [4];
   logic [3:0]  exp_valid, exp_ov, exp_un;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         mq[i].delete();
         exp_dout[i] = '0;
      end
      exp_valid = '0;
      exp_ov    = '0;
      exp_un    = '0;
   endtask

   task automatic model_step(input logic [3:0] p, input logic [3:0] q, input logic [11:0] d);
      for (int i = 0; i < 4; i++) begin
         bit do_pop, do_push;
         do_pop  = q[i] && (mq[i].size() > 0);
         do_push = p[i] && ((mq[i].size() < 8) || do_pop);
         if (q[i] && mq[i].size() == 0) exp_un[i] = 1'b1;
         if (p[i] && !do_push)          exp_ov[i] = 1'b1;
         exp_valid[i] = do_pop;
         if (do_pop)  exp_dout[i] = mq[i].pop_front();
         if (do_push) mq[i].push_back(d);
      end
   endtask

   task automatic check_all();
      logic [47:0] ed;
      logic [3:0]  ee, ef, eaf, eae;
      for (int i = 0; i < 4; i++) begin
         ed[i*12 +: 12] = exp_dout[i];
         ee[i]  = (mq[i].size() == 0);
         ef[i]  = (mq[i].size() == 8);
         eaf[i] = (mq[i].size() >= 6);
         eae[i] = (mq[i].size() <= 2);
      end
      chk("data_out",      bus.data_out,      ed);
      chk("valid_out",     bus.valid_out,     exp_valid);
      chk("empty",         bus.empty,         ee);
      chk("full",          bus.full,          ef);
      chk("almost_full",   bus.almost_full,   eaf);
      chk("almost_empty",  bus.almost_empty,  eae);
      chk("err_overflow",  bus.err_overflow,  exp_ov);
      chk("err_underflow", bus.err_underflow, exp_un);
   endtask

   task automatic cycle(input logic [3:0] p, input logic [3:0] q, input logic [11:0] d);
      bus.push    = p;
      bus.pop     = q;
      bus.data_in = d;
      @(posedge clk);
      #1;
      model_step(p, q, d);
      check_all();
   endtask

   task automatic do_reset(input int n);
      reset       = 1'b1;
      bus.push    = 4'hF;
      bus.pop     = 4'hF;
      bus.data_in = 12'hFFF;
      repeat (n) @(posedge clk);
      #1;
      model_clear();
      check_all();
      reset    = 1'b0;
      bus.push = '0;
      bus.pop  = '0;
   endtask

   initial begin
      int guard;
      reset       = 1'b1;
      bus.push    = '0;
      bus.pop     = '0;
      bus.data_in = '0;
      model_clear();

      // 1: reset held two cycles with all push/pop asserted
      do_reset(2);
      chk("rst_empty", bus.empty, 64'hF);
      chk("rst_ae",    bus.almost_empty, 64'hF);

      // 2: order and latency on FIFO 2
      cycle(4'b0100, 4'b0000, 12'h801);
      cycle(4'b0100, 4'b0000, 12'h802);
      cycle(4'b0100, 4'b0000, 12'h803);
      cycle(4'b0000, 4'b0100, 12'h000);
      chk("ord_w1", bus.data_out[35:24], 64'h801);
      chk("ord_v1", bus.valid_out, 64'h4);
      cycle(4'b0000, 4'b0100, 12'h000);
      chk("ord_w2", bus.data_out[35:24], 64'h802);
      cycle(4'b0000, 4'b0100, 12'h000);
      chk("ord_w3", bus.data_out[35:24], 64'h803);
      chk("ord_others", {bus.data_out[47:36], bus.data_out[23:0]}, 64'h0);
      cycle(4'b0000, 4'b0000, 12'h000);
      chk("ord_v_drop", bus.valid_out, 64'h0);

      // 3: thresholds on FIFO 0
      for (int k = 0; k < 5; k++) cycle(4'b0001, 4'b0000, 12'h100 + 12'(k));
      chk("af_below", bus.almost_full[0], 64'h0);
      cycle(4'b0001, 4'b0000, 12'h105);
      chk("af_rise", bus.almost_full[0], 64'h1);
      cycle(4'b0001, 4'b0000, 12'h106);
      cycle(4'b0001, 4'b0000, 12'h107);
      chk("full0", bus.full[0], 64'h1);
      chk("ov_before", bus.err_overflow[0], 64'h0);
      cycle(4'b0001, 4'b0000, 12'h1FF);
      chk("ov_set", bus.err_overflow[0], 64'h1);
      chk("full0_hold", bus.full[0], 64'h1);

      // 4: FIFO 1 full with simultaneous push+pop
      for (int k = 0; k < 8; k++) cycle(4'b0010, 4'b0000, 12'h400 + 12'(k));
      cycle(4'b0010, 4'b0010, 12'h4AA);
      chk("fpp_out", bus.data_out[23:12], 64'h400);
      chk("fpp_full", bus.full[1], 64'h1);
      chk("fpp_no_ov", bus.err_overflow[1], 64'h0);
      for (int k = 0; k < 8; k++) cycle(4'b0000, 4'b0010, 12'h000);
      chk("fpp_last", bus.data_out[23:12], 64'h4AA);
      chk("fpp_empty", bus.empty[1], 64'h1);

      // 5: pop+push on empty FIFO 3
      cycle(4'b1000, 4'b1000, 12'hC55);
      chk("emp_un", bus.err_underflow[3], 64'h1);
      chk("emp_valid", bus.valid_out[3], 64'h0);
      chk("emp_notempty", bus.empty[3], 64'h0);
      cycle(4'b0000, 4'b1000, 12'h000);
      chk("emp_word", bus.data_out[47:36], 64'hC55);

      // 6: wrap traffic on FIFO 0, then reset at count 5
      do_reset(1);
      for (int k = 0; k < 20; k++)
         cycle({3'b0, 1'($urandom_range(0, 3) != 0)}, {3'b0, 1'($urandom_range(0, 1))},
               12'($urandom));
      guard = 0;
      while (mq[0].size() != 5 && guard < 50) begin
         if (mq[0].size() < 5) cycle(4'b0001, 4'b0000, 12'($urandom));
         else                  cycle(4'b0000, 4'b0001, 12'h000);
         guard++;
      end
      chk("reach_cnt5", 64'(mq[0].size()), 64'd5);
      do_reset(1);
      chk("mid_rst_empty", bus.empty[0], 64'h1);
      cycle(4'b0001, 4'b0000, 12'h111);
      cycle(4'b0001, 4'b0000, 12'h222);
      cycle(4'b0000, 4'b0001, 12'h000);
      chk("post_rst_first", bus.data_out[11:0], 64'h111);

      // random traffic on all four classes, long enough to wrap repeatedly
      for (int k = 0; k < 400; k++) begin
         if (k == 200) do_reset(1);
         cycle(4'($urandom), 4'($urandom), 12'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
